// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_queue
//  Purpose  : Instruction fetch queue. Holds a fetch PC (fpc) that drives the
//             instruction cache, and buffers returned {pc, ir} pairs in a
//             circular buffer that feeds the predecode stage.
//  Ports    :
//    clk        in   clock, rising-edge
//    rst_n      in   synchronous active-low reset
//    flush      in   redirect request (branch/jump resolution)
//    flush_pc   in   redirect target (low two bits ignored)
//    imem_req   out  fetch request to the instruction cache
//    imem_addr  out  fetch address (= fpc)
//    imem_valid in   imem_rdata valid this cycle (low = miss)
//    imem_rdata in   fetched instruction word
//    stall_pd   in   predecode stall
//    pd_valid   out  head entry valid
//    pd_pc      out  head entry PC (fpc when the queue is empty)
//    pd_ir      out  head entry instruction (NOP when nothing valid)
//    count      out  current occupancy
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic [63:0]                flush_pc,
  output logic                       imem_req,
  output logic [63:0]                imem_addr,
  input  logic                       imem_valid,
  input  logic [31:0]                imem_rdata,
  input  logic                       stall_pd,
  output logic                       pd_valid,
  output logic [63:0]                pd_pc,
  output logic [31:0]                pd_ir,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int                AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int                CW         = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]     FULL_COUNT = CW'(DEPTH);
  localparam logic [31:0]       NOP        = 32'h0000_0013;

  logic [63:0]   pc_mem [DEPTH];
  logic [31:0]   ir_mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] occ;
  logic [63:0]   fpc;

  logic          is_empty;
  logic          is_full;
  logic          push;
  logic          pop;
  logic [63:0]   flush_target;

  assign is_empty     = (occ == '0);
  assign is_full      = (occ == FULL_COUNT);
  // Redirect targets are forced to a 4-byte boundary.
  assign flush_target = flush_pc & ~64'h3;

  // Full blocks the request even if a pop happens this cycle, so a freed slot
  // is only refilled starting the following cycle.
  assign imem_req  = rst_n && !flush && !is_full;
  assign imem_addr = fpc;

  assign push = imem_req && imem_valid;
  assign pop  = pd_valid && !stall_pd;

  assign pd_valid = rst_n && !is_empty;
  assign pd_pc    = is_empty ? fpc : pc_mem[rd_ptr];
  assign pd_ir    = pd_valid ? ir_mem[rd_ptr] : NOP;
  assign count    = occ;

  // Entry storage carries no reset; validity is tracked by occ alone.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr] <= fpc;
      ir_mem[wr_ptr] <= imem_rdata;
    end
  end

  // Reset beats flush, flush beats push/pop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fpc    <= RESET_PC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
    end else if (flush) begin
      fpc    <= flush_target;
      rd_ptr <= wr_ptr;
      occ    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
        fpc    <= fpc + 64'd4;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        occ <= occ + CW'(1);
      end else if (pop && !push) begin
        occ <= occ - CW'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_queue
//  Purpose  : Self-checking bench for fetch_queue: a table of per-cycle input
//             and expected-output records, then a streaming sequence with
//             pointer wraparound.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [63:0] flush_pc;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic        stall_pd;
  logic        pd_valid;
  logic [63:0] pd_pc;
  logic [31:0] pd_ir;
  logic [2:0]  count;

  int checks   = 0;
  int failures = 0;

  fetch_queue #(.DEPTH(4), .RESET_PC(64'h0000_0000_8000_0000)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .flush_pc   (flush_pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_valid (imem_valid),
    .imem_rdata (imem_rdata),
    .stall_pd   (stall_pd),
    .pd_valid   (pd_valid),
    .pd_pc      (pd_pc),
    .pd_ir      (pd_ir),
    .count      (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        flush;
    logic [63:0] flush_pc;
    logic        iv;
    logic [31:0] rd;
    logic        st;
    logic        req;
    logic [63:0] addr;
    logic        pv;
    logic [63:0] ppc;
    logic        chk_pc;
    logic [31:0] pir;
    logic [2:0]  cnt;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs [NV];

  function automatic vec_t mkv(logic r, logic f, logic [63:0] fp, logic iv,
                               logic [31:0] rd, logic st, logic req,
                               logic [63:0] addr, logic pv, logic [63:0] ppc,
                               logic chk_pc, logic [31:0] pir, logic [2:0] cnt);
    vec_t v;
    v.rst_n = r;  v.flush = f;  v.flush_pc = fp; v.iv = iv; v.rd = rd;
    v.st = st;    v.req = req;  v.addr = addr;   v.pv = pv; v.ppc = ppc;
    v.chk_pc = chk_pc; v.pir = pir; v.cnt = cnt;
    return v;
  endfunction

  function automatic logic [31:0] insn(logic [63:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  task automatic chk(string name, int idx, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d actual=%h required=%h", name, idx, act, exp);
    end
  endtask

  localparam logic [31:0] NOP = 32'h0000_0013;

  initial begin
    //                 rst fl flush_pc            iv rdata         st  req addr                 pv pd_pc               cp pd_ir         cnt
    vecs[0]  = mkv(0, 0, 64'h0,                0, 32'h0,         1,  0, 64'h8000_0000,        0, 64'h8000_0000,      1, NOP,          3'd0);
    // release reset, fill with predecode stalled
    vecs[1]  = mkv(1, 0, 64'h0,                1, 32'hC0DE_0000, 1,  1, 64'h8000_0000,        0, 64'h8000_0000,      1, NOP,          3'd0);
    vecs[2]  = mkv(1, 0, 64'h0,                1, 32'hC0DE_0004, 1,  1, 64'h8000_0004,        1, 64'h8000_0000,      1, 32'hC0DE_0000, 3'd1);
    vecs[3]  = mkv(1, 0, 64'h0,                1, 32'hC0DE_0008, 1,  1, 64'h8000_0008,        1, 64'h8000_0000,      1, 32'hC0DE_0000, 3'd2);
    vecs[4]  = mkv(1, 0, 64'h0,                1, 32'hC0DE_000C, 1,  1, 64'h8000_000C,        1, 64'h8000_0000,      1, 32'hC0DE_0000, 3'd3);
    vecs[5]  = mkv(1, 0, 64'h0,                1, 32'hC0DE_0010, 1,  0, 64'h8000_0010,        1, 64'h8000_0000,      1, 32'hC0DE_0000, 3'd4);
    vecs[6]  = mkv(1, 0, 64'h0,                1, 32'hC0DE_0010, 1,  0, 64'h8000_0010,        1, 64'h8000_0000,      1, 32'hC0DE_0000, 3'd4);
    // full: one pop, no push in the same cycle
    vecs[7]  = mkv(1, 0, 64'h0,                1, 32'hC0DE_0010, 0,  0, 64'h8000_0010,        1, 64'h8000_0000,      1, 32'hC0DE_0000, 3'd4);
    // request resumes at +0x10; steady stream from here
    vecs[8]  = mkv(1, 0, 64'h0,                1, 32'hC0DE_0010, 0,  1, 64'h8000_0010,        1, 64'h8000_0004,      1, 32'hC0DE_0004, 3'd3);
    vecs[9]  = mkv(1, 0, 64'h0,                1, 32'hC0DE_0014, 0,  1, 64'h8000_0014,        1, 64'h8000_0008,      1, 32'hC0DE_0008, 3'd3);
    vecs[10] = mkv(1, 0, 64'h0,                1, 32'hC0DE_0018, 0,  1, 64'h8000_0018,        1, 64'h8000_000C,      1, 32'hC0DE_000C, 3'd3);
    // flush to unaligned target with a simultaneous response
    vecs[11] = mkv(1, 1, 64'h8000_1003,        1, 32'hC0DE_001C, 0,  0, 64'h8000_001C,        1, 64'h8000_0010,      1, 32'hC0DE_0010, 3'd3);
    vecs[12] = mkv(1, 0, 64'h0,                0, 32'h0,         0,  1, 64'h8000_1000,        0, 64'h8000_1000,      1, NOP,          3'd0);
    // imem_valid 1,0,0,1 with no stall
    vecs[13] = mkv(1, 0, 64'h0,                1, 32'hC0DE_1000, 0,  1, 64'h8000_1000,        0, 64'h8000_1000,      1, NOP,          3'd0);
    vecs[14] = mkv(1, 0, 64'h0,                0, 32'h0,         0,  1, 64'h8000_1004,        1, 64'h8000_1000,      1, 32'hC0DE_1000, 3'd1);
    vecs[15] = mkv(1, 0, 64'h0,                0, 32'h0,         0,  1, 64'h8000_1004,        0, 64'h8000_1004,      1, NOP,          3'd0);
    vecs[16] = mkv(1, 0, 64'h0,                1, 32'hC0DE_1004, 0,  1, 64'h8000_1004,        0, 64'h8000_1004,      1, NOP,          3'd0);
    vecs[17] = mkv(1, 0, 64'h0,                1, 32'hC0DE_1008, 1,  1, 64'h8000_1008,        1, 64'h8000_1004,      1, 32'hC0DE_1004, 3'd1);
    // reset for one cycle with two entries queued
    vecs[18] = mkv(0, 0, 64'h0,                1, 32'hC0DE_100C, 0,  0, 64'h8000_100C,        0, 64'h0,              0, NOP,          3'd2);
    vecs[19] = mkv(1, 0, 64'h0,                0, 32'h0,         0,  1, 64'h8000_0000,        0, 64'h8000_0000,      1, NOP,          3'd0);
    // back-to-back flushes: the last target wins
    vecs[20] = mkv(1, 1, 64'h8000_2000,        1, 32'hDEAD_0000, 0,  0, 64'h8000_0000,        0, 64'h8000_0000,      1, NOP,          3'd0);
    vecs[21] = mkv(1, 1, 64'h8000_3006,        1, 32'hDEAD_0001, 0,  0, 64'h8000_2000,        0, 64'h8000_2000,      1, NOP,          3'd0);
    vecs[22] = mkv(1, 0, 64'h0,                0, 32'h0,         1,  1, 64'h8000_3004,        0, 64'h8000_3004,      1, NOP,          3'd0);

    rst_n = 1'b0; flush = 1'b0; flush_pc = '0;
    imem_valid = 1'b0; imem_rdata = '0; stall_pd = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      rst_n      = vecs[i].rst_n;
      flush      = vecs[i].flush;
      flush_pc   = vecs[i].flush_pc;
      imem_valid = vecs[i].iv;
      imem_rdata = vecs[i].rd;
      stall_pd   = vecs[i].st;
      #1;
      chk("imem_req",  i, 64'(imem_req),  64'(vecs[i].req));
      chk("imem_addr", i, imem_addr,      vecs[i].addr);
      chk("pd_valid",  i, 64'(pd_valid),  64'(vecs[i].pv));
      if (vecs[i].chk_pc) chk("pd_pc", i, pd_pc, vecs[i].ppc);
      chk("pd_ir",     i, 64'(pd_ir),     64'(vecs[i].pir));
      chk("count",     i, 64'(count),     64'(vecs[i].cnt));
    end

    // Streaming: reset, queue two entries, then 12 cycles of one-in/one-out
    // so both pointers wrap several times.
    begin
      logic [63:0] fa;
      logic [63:0] hp;
      @(negedge clk);
      rst_n = 1'b0; flush = 1'b0; imem_valid = 1'b0; stall_pd = 1'b1;
      @(negedge clk);
      rst_n = 1'b1; imem_valid = 1'b1;
      fa = 64'h8000_0000;
      hp = fa;
      for (int k = 0; k < 2; k++) begin
        imem_rdata = insn(fa);
        @(negedge clk);
        fa = fa + 64'd4;
      end
      stall_pd = 1'b0;
      for (int k = 0; k < 12; k++) begin
        imem_rdata = insn(fa);
        #1;
        chk("stream_addr",  100 + k, imem_addr,      fa);
        chk("stream_pc",    100 + k, pd_pc,          hp);
        chk("stream_ir",    100 + k, 64'(pd_ir),     64'(insn(hp)));
        chk("stream_count", 100 + k, 64'(count),     64'd2);
        @(negedge clk);
        fa = fa + 64'd4;
        hp = hp + 64'd4;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter: DEPTH, 4, number of queue entries; power of two, 2..8.
REQ-002 Parameter: RESET_PC, 64'h0000_0000_8000_0000, fetch address loaded on reset.
REQ-003 Port: clk  input  1  clock; all state changes on the rising edge.
REQ-004 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-005 Port: flush  input  1  redirect request from branch/jump resolution.
REQ-006 Port: flush_pc  input  64  redirect target address.
REQ-007 Port: imem_req  output  1  fetch request to instruction cache.
REQ-008 Port: imem_addr  output  64  fetch address, equal to the internal fetch PC (fpc).
REQ-009 Port: imem_valid  input  1  imem_rdata valid this cycle; low means cache miss (stall_imem).
REQ-010 Port: imem_rdata  input  32  fetched instruction word.
REQ-011 Port: stall_pd  input  1  predecode stage stall from the control unit.
REQ-012 Port: pd_valid  output  1  head entry valid for predecode.
REQ-013 Port: pd_pc  output  64  PC of the head entry.
REQ-014 Port: pd_ir  output  32  instruction of the head entry.
REQ-015 Port: count  output  clog2(DEPTH)+1  current occupancy.

Function
REQ-016 Storage: circular buffer of DEPTH entries {pc[63:0], ir[31:0]}; read pointer, write pointer and count registers.
REQ-017 imem_req = rst_n && !flush && (count < DEPTH); imem_addr = fpc, always combinational from the register.
REQ-018 Push when imem_req && imem_valid: write {fpc, imem_rdata} at the write pointer, advance it modulo DEPTH, fpc <= fpc + 4; 64-bit wrap, no carry-out.
REQ-019 No push when imem_valid is low: fpc, the write pointer and count hold for that cycle.
REQ-020 pd_valid = (count != 0); pd_pc/pd_ir come combinationally from the head entry.
REQ-021 When the queue is empty: pd_ir = 32'h0000_0013 (NOP), pd_pc = fpc.
REQ-022 Pop when pd_valid && !stall_pd: advance the read pointer modulo DEPTH.
REQ-023 Simultaneous push and pop: count unchanged, both pointers advance; push/pop latency is one cycle (an entry pushed in cycle N is at the head in cycle N+1 when the queue was empty).
REQ-024 Full (count == DEPTH): imem_req low; a pop in the same cycle does not enable a push, so the request resumes the following cycle.
REQ-025 Empty with stall_pd high: no pop, no underflow, pointers unchanged.
REQ-026 flush has priority over push and pop: count <= 0, read pointer <= write pointer, fpc <= {flush_pc[63:2], 2'b00}; any same-cycle imem response is discarded.
REQ-027 Cycle after flush: pd_valid = 0; the first request is issued at imem_addr = the aligned flush_pc.
REQ-028 flush asserted on consecutive cycles: the last flush_pc wins.
REQ-029 Queue contents never change on stall_pd alone; only flush and reset drop entries.

Reset
REQ-030 On rst_n low at a clock edge: fpc <= RESET_PC, pointers <= 0, count <= 0; this overrides flush, push and pop.
REQ-031 While rst_n is low: imem_req = 0, pd_valid = 0, pd_ir = NOP.
REQ-032 Reset asserted mid-operation discards all queued entries and any in-progress response.

Verification
REQ-033 Release reset, imem_valid=1, stall_pd=1 for 6 cycles -> pushes at 0x80000000, +4, +8, +C, then count=4, imem_req=0, pd_pc=0x80000000.
REQ-034 With the queue full, drop stall_pd for 1 cycle -> one pop, count=3; imem_req=1 on the next cycle with imem_addr=0x80000010.
REQ-035 Steady state imem_valid=1, stall_pd=0 -> one instruction per cycle, count constant, pd_pc increments by 4 each cycle.
REQ-036 With count=3, assert flush with flush_pc=0x80001003 together with imem_valid=1 -> next cycle count=0, pd_ir=0x00000013, imem_addr=0x80001000.
REQ-037 imem_valid toggled 1,0,0,1 with stall_pd=0 -> pd_valid follows with one-cycle latency, no duplicated or skipped PCs.
REQ-038 rst_n low for 1 cycle with count=2 -> count=0, fpc=0x80000000, pd_valid=0 on the following cycle.
